// File: rtl/adder_tree_feeder.sv
// Serial-to-parallel operand feeder for the 8-input adder tree: packs a word stream into zero-padded frames.
// Optional macro ADDER_TREE_FEEDER_BACK_TO_BACK_EN lets the next frame start filling in the cycle its predecessor is taken.

module adder_tree_feeder_lane #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic         clr_en,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)         q <= '0;
        else if (wr_en)  q <= din;
        else if (clr_en) q <= '0;
    end
endmodule

module adder_tree_feeder #(
    parameter int ADDER_WIDTH  = 14,
    parameter int NUM_OPERANDS = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ADDER_WIDTH-1:0]              in_data,
    input  logic                                in_valid,
    input  logic                                in_last,
    output logic                                in_ready,
    output logic [NUM_OPERANDS*ADDER_WIDTH-1:0] out_ops,
    output logic [$clog2(NUM_OPERANDS):0]       out_count,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [15:0]                         frames_done
);
    localparam int IW = $clog2(NUM_OPERANDS);
    localparam int CW = IW + 1;

    typedef enum logic {FILL, HOLD} state_t;

    state_t                                     state, state_nx;
    logic [IW-1:0]                              idx, idx_nx, wr_idx;
    logic [CW-1:0]                              count_nx;
    logic                                       accept, take, close;
    logic [NUM_OPERANDS-1:0][ADDER_WIDTH-1:0]   lanes;

`ifdef ADDER_TREE_FEEDER_BACK_TO_BACK_EN
    assign in_ready = !rst && ((state == FILL) || out_ready);
`else
    assign in_ready = !rst && (state == FILL);
`endif

    assign accept = in_valid && in_ready;
    assign take   = out_valid && out_ready;
    // A word accepted in HOLD can only be the first word of the next frame.
    assign wr_idx = (state == FILL) ? idx : '0;
    assign close  = accept && (in_last || (wr_idx == IW'(NUM_OPERANDS-1)));

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        count_nx = out_count;
        if (state == FILL || take) begin
            if (close) begin
                state_nx = HOLD;
                idx_nx   = '0;
                count_nx = CW'(wr_idx) + CW'(1);
            end else if (accept) begin
                state_nx = FILL;
                idx_nx   = wr_idx + IW'(1);
            end else begin
                state_nx = FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            idx         <= '0;
            out_count   <= '0;
            out_valid   <= 1'b0;
            frames_done <= '0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            out_count <= count_nx;
            out_valid <= (state_nx == HOLD);
            if (take) frames_done <= frames_done + 16'd1;
        end
    end

    // Lanes above the closing word are cleared so short frames sum correctly.
    for (genvar k = 0; k < NUM_OPERANDS; k++) begin : g_lane
        adder_tree_feeder_lane #(.W(ADDER_WIDTH)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (accept && (wr_idx == IW'(k))),
            .clr_en (close && (IW'(k) > wr_idx)),
            .din    (in_data),
            .q      (lanes[k])
        );
    end

    assign out_ops = lanes;
endmodule
